// File: rtl/receiver_event_fifo_if.sv
// receiver_event_fifo_if: valid/ready bundle carrying captured sensor events downstream
// Ports: out_valid/out_sensor_id/out_data/out_timestamp flow master->slave, out_ready flows slave->master
interface receiver_event_fifo_if #(parameter int ID_W = 3);
    logic            out_valid;
    logic            out_ready;
    logic [ID_W-1:0] out_sensor_id;
    logic [16:0]     out_data;
    logic [23:0]     out_timestamp;
    modport master (output out_valid, out_sensor_id, out_data, out_timestamp, input out_ready);
    modport slave  (input out_valid, out_sensor_id, out_data, out_timestamp, output out_ready);
endinterface

// File: rtl/receiver_event_fifo.sv
// receiver_event_fifo: round-robin capture of decoder words into a FWFT FIFO with per-channel clear pulses
// Ports: clk_96MHz/reset (async, active-high); data_availible/decoded_data/timestamp_last_data from decoders;
//        reset_decoder back to decoders; out_if master handshake to the serialiser; fifo_count occupancy;
//        full_stall sticky flag for a request refused while full
module receiver_event_fifo #(
    parameter int NUM_RECEIVERS = 4,
    parameter int DEPTH         = 8,
    parameter int ID_W          = 3
) (
    input  logic                        clk_96MHz,
    input  logic                        reset,
    input  logic [NUM_RECEIVERS-1:0]    data_availible,
    input  logic [17*NUM_RECEIVERS-1:0] decoded_data,
    input  logic [24*NUM_RECEIVERS-1:0] timestamp_last_data,
    output logic [NUM_RECEIVERS-1:0]    reset_decoder,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic                        full_stall,
    receiver_event_fifo_if.master       out_if
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [ID_W-1:0]          rr_q, rr_d;
    logic [NUM_RECEIVERS-1:0] rst_dec_q, rst_dec_d, mask_q, mask_d;
    logic                     boot_q, boot_d, stall_q, stall_d;
    logic [ID_W-1:0]          mem_id_q   [DEPTH];
    logic [16:0]              mem_data_q [DEPTH];
    logic [23:0]              mem_ts_q   [DEPTH];
    logic [NUM_RECEIVERS-1:0] eligible;
    logic [ID_W-1:0]          gnt_idx;
    logic                     gnt_found, push_ok, push, pop;
    always_comb begin
        // A channel stays masked while its clear pulse is out and one cycle after, so the decoder can drop its flag
        eligible  = data_availible & ~rst_dec_q & ~mask_q;
        pop       = out_if.out_valid && out_if.out_ready;
        push_ok   = (count_q < CW'(DEPTH)) || pop;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int i = 1; i <= NUM_RECEIVERS; i++) begin
            if (!gnt_found && eligible[(int'(rr_q) + i) % NUM_RECEIVERS]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_W'((int'(rr_q) + i) % NUM_RECEIVERS);
            end
        end
        push      = gnt_found && push_ok;
        wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        rr_d      = push ? gnt_idx : rr_q;
        rst_dec_d = push ? NUM_RECEIVERS'(1) << gnt_idx : '0;
        // The all-ones pulse after reset is not a capture, so it must not extend into a mask cycle
        mask_d    = boot_q ? '0 : rst_dec_q;
        boot_d    = 1'b0;
        stall_d   = stall_q | (gnt_found & ~push_ok);
    end
    always_ff @(posedge clk_96MHz or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rr_q      <= ID_W'(NUM_RECEIVERS - 1);
            rst_dec_q <= '1;
            mask_q    <= '0;
            boot_q    <= 1'b1;
            stall_q   <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rr_q      <= rr_d;
            rst_dec_q <= rst_dec_d;
            mask_q    <= mask_d;
            boot_q    <= boot_d;
            stall_q   <= stall_d;
        end
    end
    always_ff @(posedge clk_96MHz) begin
        if (push) begin
            mem_id_q[wr_ptr_q]   <= gnt_idx;
            mem_data_q[wr_ptr_q] <= decoded_data[17*gnt_idx +: 17];
            mem_ts_q[wr_ptr_q]   <= timestamp_last_data[24*gnt_idx +: 24];
        end
    end
    assign out_if.out_valid     = count_q != '0;
    assign out_if.out_sensor_id = mem_id_q[rd_ptr_q];
    assign out_if.out_data      = mem_data_q[rd_ptr_q];
    assign out_if.out_timestamp = mem_ts_q[rd_ptr_q];
    assign reset_decoder        = rst_dec_q;
    assign fifo_count           = count_q;
    assign full_stall           = stall_q;
endmodule

// File: tb/tb_receiver_event_fifo.sv
// tb_receiver_event_fifo: directed checks of capture order, handshake, full/backpressure, wrap and reset
module tb_receiver_event_fifo;
    localparam int N  = 4;
    localparam int D  = 8;
    localparam int IW = 3;
    logic            clk_96MHz = 1'b0;
    logic            reset = 1'b1;
    logic [N-1:0]    avail = '0;
    logic [N-1:0]    rearm = '0;
    logic [16:0]     data [N];
    logic [23:0]     ts   [N];
    int              cnt  [N];
    logic [17*N-1:0] dd;
    logic [24*N-1:0] tsb;
    logic [N-1:0]    reset_decoder;
    logic [3:0]      fifo_count;
    logic            full_stall;
    int              checks = 0;
    int              errors = 0;
    receiver_event_fifo_if #(.ID_W(IW)) oif();
    receiver_event_fifo #(.NUM_RECEIVERS(N), .DEPTH(D), .ID_W(IW)) dut (
        .clk_96MHz(clk_96MHz),
        .reset(reset),
        .data_availible(avail),
        .decoded_data(dd),
        .timestamp_last_data(tsb),
        .reset_decoder(reset_decoder),
        .fifo_count(fifo_count),
        .full_stall(full_stall),
        .out_if(oif)
    );
    always #5 clk_96MHz = ~clk_96MHz;
    always_comb begin
        dd  = '0;
        tsb = '0;
        for (int k = 0; k < N; k++) begin
            dd[17*k +: 17]  = data[k];
            tsb[24*k +: 24] = ts[k];
        end
    end
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // One clock; decoders drop their flag on an edge where they saw reset_decoder, optionally re-raising 2 cycles later
    task automatic tick();
        logic [N-1:0] rd;
        rd = reset_decoder;
        @(posedge clk_96MHz);
        #1;
        for (int k = 0; k < N; k++) begin
            if (rd[k]) begin
                avail[k] = 1'b0;
                cnt[k]   = rearm[k] ? 2 : 0;
            end else if (cnt[k] != 0) begin
                cnt[k]--;
                if (cnt[k] == 0) avail[k] = 1'b1;
            end
        end
    endtask
    task automatic do_reset();
        reset = 1'b1;
        #1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask
    function automatic logic [63:0] head();
        return {20'd0, oif.out_sensor_id, oif.out_data, oif.out_timestamp};
    endfunction
    function automatic logic [63:0] ent(input int id, input logic [16:0] d, input logic [23:0] t);
        return {20'd0, IW'(id), d, t};
    endfunction
    initial begin
        int got;
        for (int k = 0; k < N; k++) begin
            data[k] = '0;
            ts[k]   = '0;
            cnt[k]  = 0;
        end
        oif.out_ready = 1'b0;
        #12;
        check("rst_valid", oif.out_valid, 0);
        check("rst_count", fifo_count, 0);
        check("rst_rdec", reset_decoder, 4'b1111);
        check("rst_stall", full_stall, 0);
        @(posedge clk_96MHz);
        #1;
        reset = 1'b0;
        tick();
        check("rel_rdec", reset_decoder, 0);
        check("rel_valid", oif.out_valid, 0);
        data[2] = 17'h1ABCD;
        ts[2] = 24'h000100;
        avail[2] = 1'b1;
        oif.out_ready = 1'b1;
        tick();
        check("t1_rdec", reset_decoder, 4'b0100);
        check("t1_valid", oif.out_valid, 1);
        check("t1_head", head(), ent(2, 17'h1ABCD, 24'h000100));
        check("t1_count", fifo_count, 1);
        tick();
        check("t1_rdec_off", reset_decoder, 0);
        check("t1_valid_off", oif.out_valid, 0);
        check("t1_count_end", fifo_count, 0);
        do_reset();
        oif.out_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            data[k] = 17'h0A000 + 17'(k);
            ts[k]   = 24'h200000 + 24'(k);
        end
        avail = 4'hF;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t2_grant", reset_decoder, 64'(1) << i);
        end
        check("t2_count", fifo_count, 4);
        tick();
        check("t2_idle", reset_decoder, 0);
        oif.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t2_pop_valid", oif.out_valid, 1);
            check("t2_pop_head", head(), ent(i, 17'h0A000 + 17'(i), 24'h200000 + 24'(i)));
            tick();
        end
        check("t2_drained", fifo_count, 0);
        check("t2_valid_off", oif.out_valid, 0);
        do_reset();
        oif.out_ready = 1'b1;
        rearm = 4'b1010;
        avail = 4'b1010;
        got = 0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            tick();
            if (reset_decoder != 0) begin
                check("t3_grant", reset_decoder, (got % 2) != 0 ? 4'b1000 : 4'b0010);
                got++;
            end
        end
        check("t3_grants_seen", got, 6);
        rearm = '0;
        for (int k = 0; k < N; k++) cnt[k] = 0;
        do_reset();
        oif.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            data[0] = 17'h00100 + 17'(i);
            ts[0] = 24'h300000 + 24'(i);
            avail[0] = 1'b1;
            tick();
            check("t4_fill_grant", reset_decoder, 4'b0001);
            tick();
            tick();
        end
        check("t4_full_count", fifo_count, 8);
        check("t4_stall_clear", full_stall, 0);
        data[0] = 17'h00108;
        ts[0] = 24'h300008;
        avail[0] = 1'b1;
        tick();
        check("t4_refused", reset_decoder, 0);
        check("t4_stall_set", full_stall, 1);
        check("t4_count_held", fifo_count, 8);
        tick();
        check("t4_still_refused", reset_decoder, 0);
        check("t4_head0", head(), ent(0, 17'h00100, 24'h300000));
        oif.out_ready = 1'b1;
        tick();
        oif.out_ready = 1'b0;
        check("t4_pushpop_grant", reset_decoder, 4'b0001);
        check("t4_pushpop_count", fifo_count, 8);
        check("t4_head1", head(), ent(0, 17'h00101, 24'h300001));
        oif.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t4_drain", head(), ent(0, 17'h00101 + 17'(i), 24'h300001 + 24'(i)));
            tick();
        end
        check("t4_drain_count", fifo_count, 0);
        check("t4_stall_sticky", full_stall, 1);
        for (int i = 0; i < 20; i++) begin
            data[i % 4] = 17'h1F000 + 17'(i);
            ts[i % 4] = 24'hABC000 + 24'(i);
            avail[i % 4] = 1'b1;
            tick();
            check("t5_valid", oif.out_valid, 1);
            check("t5_head", head(), ent(i % 4, 17'h1F000 + 17'(i), 24'hABC000 + 24'(i)));
        end
        tick();
        check("t5_count_end", fifo_count, 0);
        oif.out_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            data[k] = 17'h0C000 + 17'(k);
            ts[k] = 24'h500000 + 24'(k);
        end
        avail = 4'hF;
        repeat (4) tick();
        data[0] = 17'h0C0FF;
        avail[0] = 1'b1;
        tick();
        check("t6_queued", fifo_count, 5);
        reset = 1'b1;
        #1;
        check("t6_async_valid", oif.out_valid, 0);
        check("t6_async_count", fifo_count, 0);
        check("t6_async_rdec", reset_decoder, 4'b1111);
        tick();
        reset = 1'b0;
        tick();
        check("t6_rel_rdec", reset_decoder, 0);
        check("t6_rel_count", fifo_count, 0);
        data[1] = 17'h05555;
        ts[1] = 24'h777777;
        avail[1] = 1'b1;
        oif.out_ready = 1'b1;
        tick();
        check("t6_new_grant", reset_decoder, 4'b0010);
        check("t6_new_valid", oif.out_valid, 1);
        check("t6_new_head", head(), ent(1, 17'h05555, 24'h777777));
        tick();
        check("t6_new_count", fifo_count, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
